// File: rtl/reaction_pkg.sv
// Shared result codes, FSM state encoding and press-priority helper for reaction_judge.
package reaction_pkg;

    localparam logic [1:0] RES_NONE    = 2'b00;
    localparam logic [1:0] RES_HIT     = 2'b01;
    localparam logic [1:0] RES_WRONG   = 2'b10;
    localparam logic [1:0] RES_TIMEOUT = 2'b11;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_e;

    // Maps a press vector to the action code of its lowest-index set bit.
    // Button i encodes action num_btn-1-i; an empty vector yields 0.
    function automatic logic [31:0] press_to_action(input logic [31:0] press,
                                                    input int unsigned num_btn);
        logic [31:0] act;
        act = '0;
        // Walk from high to low so the lowest set index is written last.
        for (int i = 31; i >= 0; i--) begin
            if ((i < num_btn) && press[i]) begin
                act = num_btn - 1 - i;
            end
        end
        return act;
    endfunction

endpackage

// File: rtl/btn_edge_detect.sv
// Registers the button levels every cycle and flags rising edges.
module btn_edge_detect #(
    parameter int unsigned NUM_BTN = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_BTN-1:0] btn_i,
    output logic [NUM_BTN-1:0] press_o,
    output logic               any_press_o
);

    logic [NUM_BTN-1:0] btn_q;

    // Button history, updated in every FSM state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            btn_q <= '0;
        end else begin
            btn_q <= btn_i;
        end
    end

    // Rising edges only: a held button never produces a second press.
    always_comb begin
        press_o     = btn_i & ~btn_q;
        any_press_o = |press_o;
    end

endmodule

// File: rtl/reaction_judge.sv
// Per-round answer judge: hit / wrong / timeout, saturating tallies, sticky game-over.
module reaction_judge
    import reaction_pkg::*;
#(
    parameter int unsigned NUM_BTN   = 4,
    parameter int unsigned ACT_W     = 2,
    parameter int unsigned WINDOW    = 50,
    parameter int unsigned WIN_W     = 8,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned MAX_WRONG = 10
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               tick_i,
    input  logic               round_start_i,
    input  logic [ACT_W-1:0]   action_i,
    input  logic [NUM_BTN-1:0] btn_i,
    output logic [ACT_W-1:0]   operation_o,
    output logic               result_valid_o,
    output logic [1:0]         result_o,
    output logic [CNT_W-1:0]   right_time_o,
    output logic [CNT_W-1:0]   wrong_time_o,
    output logic               busy_o,
    output logic               game_over_o
);

    localparam logic [WIN_W-1:0] WinLast  = WIN_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CntMax   = '1;
    localparam logic [CNT_W-1:0] MaxWrong = CNT_W'(MAX_WRONG);

    logic [NUM_BTN-1:0] press;
    logic               any_press;
    logic [ACT_W-1:0]   press_act;

    state_e             state_q;
    logic [ACT_W-1:0]   act_q;
    logic [WIN_W-1:0]   win_q;
    logic [ACT_W-1:0]   op_q;
    logic [1:0]         res_q;
    logic               valid_q;
    logic [CNT_W-1:0]   right_q, right_d;
    logic [CNT_W-1:0]   wrong_q, wrong_d;
    logic               over_q;

    btn_edge_detect #(
        .NUM_BTN (NUM_BTN)
    ) u_edge (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .btn_i       (btn_i),
        .press_o     (press),
        .any_press_o (any_press)
    );

    // Priority-encoded press action and saturating tally increments.
    always_comb begin
        press_act = ACT_W'(press_to_action(32'(press), NUM_BTN));
        right_d   = (right_q == CntMax) ? right_q : right_q + CNT_W'(1);
        wrong_d   = (wrong_q == CntMax) ? wrong_q : wrong_q + CNT_W'(1);
    end

    // Round FSM with window counter, tallies and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            act_q   <= '0;
            win_q   <= '0;
            op_q    <= '0;
            res_q   <= RES_NONE;
            valid_q <= 1'b0;
            right_q <= '0;
            wrong_q <= '0;
            over_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (round_start_i && !over_q) begin
                        act_q   <= action_i;
                        win_q   <= '0;
                        state_q <= ARMED;
                    end
                end
                ARMED: begin
                    // A press beats a coincident final tick.
                    if (any_press) begin
                        op_q    <= press_act;
                        valid_q <= 1'b1;
                        state_q <= IDLE;
                        if (press_act == act_q) begin
                            res_q   <= RES_HIT;
                            right_q <= right_d;
                        end else begin
                            res_q   <= RES_WRONG;
                            wrong_q <= wrong_d;
                            if (wrong_d >= MaxWrong) begin
                                over_q <= 1'b1;
                            end
                        end
                    end else if (tick_i) begin
                        win_q <= win_q + WIN_W'(1);
                        if (win_q == WinLast) begin
                            res_q   <= RES_TIMEOUT;
                            valid_q <= 1'b1;
                            state_q <= IDLE;
                            wrong_q <= wrong_d;
                            if (wrong_d >= MaxWrong) begin
                                over_q <= 1'b1;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign operation_o    = op_q;
    assign result_valid_o = valid_q;
    assign result_o       = res_q;
    assign right_time_o   = right_q;
    assign wrong_time_o   = wrong_q;
    assign busy_o         = (state_q == ARMED);
    assign game_over_o    = over_q;

endmodule

// File: doc/reaction_judge.md
Name: reaction_judge

Overview:
- Parametrised answer judge for the reflex game; successor to the fixed 4-button, 50-tick judge.
- Per round: latches the expected action, opens a response window of WINDOW ticks and judges exactly one outcome: hit, wrong button or timeout.
- Keeps saturating right/wrong tallies and raises a sticky game-over once wrong answers reach a limit.
- Sits between the level/action sequencer (upstream) and the score display/LED logic (downstream).

Parameters:
- NUM_BTN, 4, number of answer buttons; button i encodes action NUM_BTN-1-i.
- ACT_W, 2, action code width; must satisfy 2^ACT_W >= NUM_BTN.
- WINDOW, 50, response window length in tick pulses; must be >= 1.
- WIN_W, 8, window counter width; must satisfy 2^WIN_W > WINDOW.
- CNT_W, 8, width of the tally counters.
- MAX_WRONG, 10, wrong-count threshold for game_over; must be >= 1 and <= 2^CNT_W-1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- tick  in  1  one-cycle time-base pulse (0.1 s)
- round_start  in  1  one-cycle pulse that opens a new round
- action  in  ACT_W  expected action, sampled on an accepted round_start
- btn  in  NUM_BTN  debounced buttons, level
- operation  out  ACT_W  action code of the last judged press
- result_valid  out  1  one-cycle pulse when a round is judged
- result  out  2  00 none, 01 hit, 10 wrong, 11 timeout; held until the next judgement
- right_time  out  CNT_W  saturating hit count
- wrong_time  out  CNT_W  saturating wrong+timeout count
- busy  out  1  high while state is ARMED
- game_over  out  1  sticky, high once wrong_time >= MAX_WRONG

Behaviour:
- One clock, synchronous active-high rst; all state updates on posedge clk.
- Reset values: state IDLE, operation 0, result 00, result_valid 0, right_time 0, wrong_time 0, busy 0, game_over 0, window counter 0, btn history 0.
- Reset mid-round abandons the round silently: no result_valid pulse.
- Press detection:
  - btn_q is registered every cycle, in every state.
  - press = btn & ~btn_q (rising edge only).
  - A button held before or across arming never counts until it is released and pressed again.
  - Several edges in one cycle: the lowest index wins.
- State IDLE:
  - round_start with game_over=0: latch action, clear window counter, go to ARMED.
  - round_start with game_over=1: ignored.
- State ARMED, press edge on button i:
  - Next cycle: operation = NUM_BTN-1-i, result_valid = 1.
  - result = 01 and right_time+1 if the code equals the latched action; otherwise result = 10 and wrong_time+1.
  - Return to IDLE.
- State ARMED, tick with no press:
  - Window counter increments.
  - On the tick where the counter equals WINDOW-1: result = 11, wrong_time+1, result_valid pulse next cycle, return to IDLE.
  - operation is unchanged on timeout.
- Press and final tick in the same cycle: the press wins and no timeout is recorded.
- round_start while ARMED: ignored; the current round continues.
- round_start in the same cycle as the judgement: ignored; a new pulse is needed once in IDLE.
- Latency: judgement registered 1 cycle after the press or final tick; busy drops in that same cycle.
- Tallies: saturate at 2^CNT_W-1 and never wrap.
- game_over: asserts in the cycle wrong_time becomes >= MAX_WRONG; cleared only by rst.
- Presses while IDLE: update btn_q only; no judgement and no counter changes.

Decomposition:
- Package reaction_pkg holds:
  - the result code constants RES_NONE, RES_HIT, RES_WRONG, RES_TIMEOUT;
  - the state encoding IDLE/ARMED;
  - a function mapping a press vector to a priority action code.
- Sub-module btn_edge_detect (parametrised by NUM_BTN) contains the btn_q register and outputs press plus an any_press flag.
- The FSM, window counter and tallies stay in reaction_judge.

Test Plan:
- Defaults, action=2, round_start, btn[1] rises 3 ticks later -> one cycle after the edge: result_valid=1, result=01, operation=2, right_time=1, busy=0.
- action=0, btn[0] pressed -> result=10, operation=3, wrong_time=1; holding btn[0] into the next round yields no judgement until it is re-pressed.
- round_start with no press -> exactly 50 ticks later: result=11, wrong_time+1, operation unchanged; btn[3] edge in the same cycle as the 50th tick -> result=01 (action=0), no timeout.
- btn[2] and btn[0] rise in the same cycle with action=3 -> result=01, operation=3 (lowest index wins).
- 10 consecutive timeouts -> game_over=1 on the 10th judgement; a further round_start is ignored (busy stays 0); with CNT_W=4, right_time stays at 15 after 16 hits.
- rst pulsed while busy=1 -> next cycle all outputs at reset values, no result_valid; a new round then behaves normally.
